// File: rtl/gemm_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gemm_mem_arbiter
//  Purpose  : Round-robin burst arbiter sharing the 128-bit GEMM memory
//             interface between the load/execute and store controllers.
//             Grants are whole bursts, capped at MAX_BURST beats. Read
//             returns are steered back to their issuer by a tag pipeline
//             matched to the memory read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module gemm_mem_arbiter #(
  parameter int MAX_BURST  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,          // asynchronous, active-low

  input  logic         ld_en,
  input  logic         ld_rdwr,
  input  logic [31:0]  ld_addr,
  input  logic [4:0]   ld_control,
  input  logic [127:0] ld_wr_data,
  input  logic         ld_last,
  output logic         ld_gnt,
  output logic         ld_rd_valid,

  input  logic         st_en,
  input  logic         st_rdwr,
  input  logic [31:0]  st_addr,
  input  logic [4:0]   st_control,
  input  logic [127:0] st_wr_data,
  input  logic         st_last,
  output logic         st_gnt,
  output logic         st_rd_valid,

  output logic [127:0] rd_data,

  output logic         mem_en,
  output logic         mem_rdwr,
  output logic [31:0]  mem_addr,
  output logic [4:0]   mem_control,
  output logic [127:0] mem_wr_data,
  input  logic         mem_ready,
  input  logic [127:0] mem_rd_data
);

  localparam int c_cnt_w = $clog2(MAX_BURST + 1);

  // Owner encoding used by last_owner and the read tags
  localparam logic c_own_ld = 1'b0;
  localparam logic c_own_st = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LD   = 2'd1,
    S_ST   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_last_owner;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [RD_LATENCY-1:0] r_tag_v;
  logic [RD_LATENCY-1:0] r_tag_o;

  logic w_own_last;
  logic w_beat;
  logic w_cap;
  logic w_release;
  logic w_tail_v;
  logic w_tail_o;

  // Grants come straight from the state register, so they are glitch-free
  // and mutually exclusive by construction.
  assign ld_gnt = (r_state == S_LD);
  assign st_gnt = (r_state == S_ST);

  // Route the owning requester onto the memory port; everything is zero in IDLE
  always_comb begin
    mem_en      = 1'b0;
    mem_rdwr    = 1'b0;
    mem_addr    = '0;
    mem_control = '0;
    mem_wr_data = '0;
    w_own_last  = 1'b0;
    case (r_state)
      S_LD: begin
        mem_en      = ld_en;
        mem_rdwr    = ld_rdwr;
        mem_addr    = ld_addr;
        mem_control = ld_control;
        mem_wr_data = ld_wr_data;
        w_own_last  = ld_last;
      end
      S_ST: begin
        mem_en      = st_en;
        mem_rdwr    = st_rdwr;
        mem_addr    = st_addr;
        mem_control = st_control;
        mem_wr_data = st_wr_data;
        w_own_last  = st_last;
      end
      default: begin
      end
    endcase
  end

  assign w_beat    = mem_en && mem_ready;
  // The beat that brings the count to MAX_BURST is the forced-release beat
  assign w_cap     = (r_cnt == c_cnt_w'(MAX_BURST - 1));
  assign w_release = w_beat && (w_own_last || w_cap);

  // Arbitration FSM with burst beat counter and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_owner <= c_own_st;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (ld_en && st_en) begin
            // Tie: the side that did not own the bus last time wins
            r_state <= (r_last_owner == c_own_st) ? S_LD : S_ST;
          end else if (ld_en) begin
            r_state <= S_LD;
          end else if (st_en) begin
            r_state <= S_ST;
          end
        end
        S_LD, S_ST: begin
          if (w_release) begin
            r_state      <= S_IDLE;
            r_last_owner <= (r_state == S_ST) ? c_own_st : c_own_ld;
            r_cnt        <= '0;
          end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Tag pipeline: one {valid, owner} stage per cycle of memory read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v <= '0;
      r_tag_o <= '0;
    end else begin
      r_tag_v[0] <= w_beat && !mem_rdwr;
      r_tag_o[0] <= (r_state == S_ST) ? c_own_st : c_own_ld;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_o[i] <= r_tag_o[i-1];
      end
    end
  end

  assign w_tail_v = r_tag_v[RD_LATENCY-1];
  assign w_tail_o = r_tag_o[RD_LATENCY-1];

  // Capture returning read data and flag it for the requester that issued it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data     <= '0;
      ld_rd_valid <= 1'b0;
      st_rd_valid <= 1'b0;
    end else begin
      ld_rd_valid <= w_tail_v && (w_tail_o == c_own_ld);
      st_rd_valid <= w_tail_v && (w_tail_o == c_own_st);
      if (w_tail_v) begin
        rd_data <= mem_rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gemm_mem_arbiter
//  Purpose  : Directed self-checking bench for gemm_mem_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_mem_arbiter;

  localparam int MAX_BURST  = 16;
  localparam int RD_LATENCY = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld_en, ld_rdwr, ld_last, ld_gnt, ld_rd_valid;
  logic [31:0]  ld_addr;
  logic [4:0]   ld_control;
  logic [127:0] ld_wr_data;
  logic         st_en, st_rdwr, st_last, st_gnt, st_rd_valid;
  logic [31:0]  st_addr;
  logic [4:0]   st_control;
  logic [127:0] st_wr_data;
  logic [127:0] rd_data;
  logic         mem_en, mem_rdwr, mem_ready;
  logic [31:0]  mem_addr;
  logic [4:0]   mem_control;
  logic [127:0] mem_wr_data, mem_rd_data;

  always #5 clk = ~clk;

  gemm_mem_arbiter #(.MAX_BURST(MAX_BURST), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_rdwr(ld_rdwr), .ld_addr(ld_addr), .ld_control(ld_control),
    .ld_wr_data(ld_wr_data), .ld_last(ld_last), .ld_gnt(ld_gnt), .ld_rd_valid(ld_rd_valid),
    .st_en(st_en), .st_rdwr(st_rdwr), .st_addr(st_addr), .st_control(st_control),
    .st_wr_data(st_wr_data), .st_last(st_last), .st_gnt(st_gnt), .st_rd_valid(st_rd_valid),
    .rd_data(rd_data),
    .mem_en(mem_en), .mem_rdwr(mem_rdwr), .mem_addr(mem_addr), .mem_control(mem_control),
    .mem_wr_data(mem_wr_data), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data)
  );

  // Memory model: returns a word derived from the address RD_LATENCY cycles later
  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h1, a};
  endfunction

  logic [31:0] mp_a [RD_LATENCY];
  logic        mp_v [RD_LATENCY];
  initial for (int i = 0; i < RD_LATENCY; i++) begin mp_v[i] = 1'b0; mp_a[i] = '0; end

  always @(posedge clk) begin
    mp_a[0] <= mem_addr;
    mp_v[0] <= mem_en && mem_ready && !mem_rdwr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      mp_a[i] <= mp_a[i-1];
      mp_v[i] <= mp_v[i-1];
    end
  end
  assign mem_rd_data = mp_v[RD_LATENCY-1] ? mem_word(mp_a[RD_LATENCY-1]) : '0;

  // Scoreboard and requester models
  int checks = 0;
  int errors = 0;

  int ld_n, ld_idx, ld_start, st_n, st_idx, st_start, stall_lo, stall_hi;
  bit ld_wr, ld_single, st_wr, st_single;
  logic [31:0] ld_base, st_base;
  bit          exp_lv [64];
  bit          exp_sv [64];
  logic [127:0] exp_d [64];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic zero_inputs();
    ld_en = 0; ld_rdwr = 0; ld_addr = '0; ld_control = '0; ld_wr_data = '0; ld_last = 0;
    st_en = 0; st_rdwr = 0; st_addr = '0; st_control = '0; st_wr_data = '0; st_last = 0;
    mem_ready = 1'b1;
  endtask

  task automatic setup_clear();
    for (int i = 0; i < 64; i++) begin exp_lv[i] = 0; exp_sv[i] = 0; exp_d[i] = '0; end
    ld_n = 0; ld_idx = 0; ld_start = 0; ld_wr = 0; ld_single = 0; ld_base = '0;
    st_n = 0; st_idx = 0; st_start = 0; st_wr = 0; st_single = 0; st_base = '0;
    stall_lo = -1; stall_hi = -2;
  endtask

  task automatic chk_all_zero(input string where);
    chk({where, " ld_gnt"},      128'(ld_gnt), '0);
    chk({where, " st_gnt"},      128'(st_gnt), '0);
    chk({where, " ld_rd_valid"}, 128'(ld_rd_valid), '0);
    chk({where, " st_rd_valid"}, 128'(st_rd_valid), '0);
    chk({where, " rd_data"},     rd_data, '0);
    chk({where, " mem_en"},      128'(mem_en), '0);
    chk({where, " mem_rdwr"},    128'(mem_rdwr), '0);
    chk({where, " mem_addr"},    128'(mem_addr), '0);
    chk({where, " mem_control"}, 128'(mem_control), '0);
    chk({where, " mem_wr_data"}, mem_wr_data, '0);
  endtask

  // Reset with requesters optionally active, leaving time at posedge+1 of cycle 0
  task automatic do_reset(input bit poke);
    rst = 1'b0;
    zero_inputs();
    if (poke) begin
      ld_en = 1; ld_rdwr = 1; ld_addr = 32'hDEAD_0000; ld_control = 5'h1F; ld_wr_data = '1;
      st_en = 1; st_rdwr = 1; st_addr = 32'hBEEF_0000; st_control = 5'h1F; st_wr_data = '1;
    end
    @(posedge clk); #1;
    if (poke) chk_all_zero("reset");
    zero_inputs();
    setup_clear();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_regs(input int c, input bit eg_ld, input bit eg_st);
    chk($sformatf("ld_gnt@%0d", c), 128'(ld_gnt), 128'(eg_ld));
    chk($sformatf("st_gnt@%0d", c), 128'(st_gnt), 128'(eg_st));
    chk($sformatf("ld_rd_valid@%0d", c), 128'(ld_rd_valid), 128'(exp_lv[c]));
    chk($sformatf("st_rd_valid@%0d", c), 128'(st_rd_valid), 128'(exp_sv[c]));
    if (exp_lv[c] || exp_sv[c]) chk($sformatf("rd_data@%0d", c), rd_data, exp_d[c]);
  endtask

  task automatic drive(input int c);
    ld_en      = (c >= ld_start) && (ld_idx < ld_n);
    ld_addr    = ld_base + 32'(ld_idx * 16);
    ld_rdwr    = ld_wr;
    ld_last    = ld_single || (ld_idx == ld_n - 1);
    ld_control = 5'h0A;
    ld_wr_data = {4{ld_addr ^ 32'h1111_0000}};
    st_en      = (c >= st_start) && (st_idx < st_n);
    st_addr    = st_base + 32'(st_idx * 16);
    st_rdwr    = st_wr;
    st_last    = st_single || (st_idx == st_n - 1);
    st_control = 5'h15;
    st_wr_data = {4{st_addr ^ 32'h2222_0000}};
    mem_ready  = !(c >= stall_lo && c <= stall_hi);
  endtask

  task automatic chk_mem(input int c, input bit eg_ld, input bit eg_st);
    logic         e_en, e_rdwr;
    logic [31:0]  e_addr;
    logic [4:0]   e_ctl;
    logic [127:0] e_wd;
    e_en   = (eg_ld && ld_en) || (eg_st && st_en);
    e_rdwr = eg_ld ? ld_rdwr : (eg_st ? st_rdwr : 1'b0);
    e_addr = eg_ld ? ld_addr : (eg_st ? st_addr : 32'h0);
    e_ctl  = eg_ld ? ld_control : (eg_st ? st_control : 5'h0);
    e_wd   = eg_ld ? ld_wr_data : (eg_st ? st_wr_data : 128'h0);
    chk($sformatf("mem_en@%0d", c), 128'(mem_en), 128'(e_en));
    chk($sformatf("mem_rdwr@%0d", c), 128'(mem_rdwr), 128'(e_rdwr));
    chk($sformatf("mem_addr@%0d", c), 128'(mem_addr), 128'(e_addr));
    chk($sformatf("mem_control@%0d", c), 128'(mem_control), 128'(e_ctl));
    chk($sformatf("mem_wr_data@%0d", c), mem_wr_data, e_wd);
    if (eg_ld && ld_en && mem_ready) begin
      if (!ld_wr) begin
        exp_lv[c + RD_LATENCY + 1] = 1;
        exp_d[c + RD_LATENCY + 1]  = mem_word(ld_addr);
      end
      ld_idx++;
    end
    if (eg_st && st_en && mem_ready) begin
      if (!st_wr) begin
        exp_sv[c + RD_LATENCY + 1] = 1;
        exp_d[c + RD_LATENCY + 1]  = mem_word(st_addr);
      end
      st_idx++;
    end
  endtask

  task automatic step(input int c, input bit eg_ld, input bit eg_st);
    chk_regs(c, eg_ld, eg_st);
    drive(c);
    #1;
    chk_mem(c, eg_ld, eg_st);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_inputs();
    setup_clear();

    // Reset values with both requesters asserting during reset
    do_reset(1'b1);

    // Single 4-beat load read burst
    ld_n = 4; ld_base = 32'h100;
    for (int c = 0; c <= 9; c++) step(c, (c >= 1 && c <= 4), 1'b0);

    // Tie after reset, then round-robin of 1-beat bursts
    do_reset(1'b0);
    ld_n = 2; ld_single = 1; ld_wr = 1; ld_base = 32'h200;
    st_n = 2; st_single = 1; st_wr = 1; st_base = 32'h300;
    for (int c = 0; c <= 9; c++) step(c, (c == 1 || c == 5), (c == 3 || c == 7));

    // Forced release of a 20-beat store burst with a load pending
    do_reset(1'b0);
    st_n = 20; st_wr = 1; st_base = 32'h1000;
    ld_n = 1; ld_single = 1; ld_wr = 1; ld_base = 32'h2000; ld_start = 1;
    for (int c = 0; c <= 26; c++)
      step(c, (c == 18), ((c >= 1 && c <= 16) || (c >= 20 && c <= 23)));

    // 8-beat load read burst with mem_ready low for cycles 3..5
    do_reset(1'b0);
    ld_n = 8; ld_base = 32'h400; stall_lo = 3; stall_hi = 5;
    for (int c = 0; c <= 16; c++) step(c, (c >= 1 && c <= 11), 1'b0);

    // Load read return lands while the store owns the bus
    do_reset(1'b0);
    ld_n = 2; ld_base = 32'h600;
    st_n = 2; st_wr = 1; st_base = 32'h700; st_start = 1;
    for (int c = 0; c <= 8; c++) step(c, (c == 1 || c == 2), (c == 4 || c == 5));

    // Asynchronous reset in the middle of a load burst with reads in flight
    do_reset(1'b0);
    ld_n = 4; ld_base = 32'h800;
    for (int c = 0; c <= 2; c++) step(c, (c >= 1), 1'b0);
    chk_regs(3, 1'b1, 1'b0);
    drive(3);
    #1 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    #1 rst = 1'b1;
    setup_clear();
    ld_n = 1; ld_single = 1; ld_wr = 1; ld_base = 32'h900;
    st_n = 1; st_single = 1; st_wr = 1; st_base = 32'hA00;
    drive(3);
    #1 chk_mem(3, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int c = 4; c <= 10; c++) begin
      chk($sformatf("post_rst rd_data@%0d", c), rd_data, '0);
      step(c, (c == 4), (c == 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
